// File: rtl/ternary_serial_adder.sv
// Bit-serial ternary adder/accumulator: one binary-coded trit per clock, LSB first.
// Trit code: 2'b00=0, 2'b01=1, 2'b10=2, 2'b11=invalid.
module ternary_serial_adder #(
   parameter int NTRITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  op,
   input  logic                  clr,
   input  logic [2*NTRITS-1:0]   a,
   input  logic [2*NTRITS-1:0]   b,
   input  logic [1:0]            cin,
   output logic                  busy,
   output logic                  done,
   output logic [2*NTRITS-1:0]   sum,
   output logic [1:0]            cout,
   output logic                  err,
   output logic [2*NTRITS-1:0]   acc
);

   localparam int W  = 2 * NTRITS;
   localparam int IW = (NTRITS > 1) ? $clog2(NTRITS) : 1;

   typedef enum logic {IDLE, RUN} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q;
   logic [W-1:0]    a_q, b_q, work_q, sum_q, acc_q;
   logic            op_q, carry_q, done_q, err_q;
   logic [1:0]      cout_q;

   logic [W-1:0]    acc_eff, b_sel, work_d;
   logic            bad_in, last;
   logic [1:0]      a_tr, b_tr, t_sum;
   logic [2:0]      t;
   logic            t_carry;

   function automatic logic has_bad(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < NTRITS; i++)
         if (v[2*i +: 2] == 2'b11) bad = 1'b1;
      return bad;
   endfunction

   // A clear on the start edge takes effect before the accumulator is used as operand B.
   assign acc_eff = clr ? '0 : acc_q;
   assign b_sel   = op ? acc_eff : b;
   assign bad_in  = has_bad(a) | has_bad(b_sel) | cin[1];
   assign last    = (idx_q == IW'(NTRITS - 1));

   // Trit arithmetic: t is at most 2+2+1=5, so the carry never exceeds 1.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
      a_tr    = a_q[{idx_q, 1'b0} +: 2];
      b_tr    = b_q[{idx_q, 1'b0} +: 2];
      t       = {1'b0, a_tr} + {1'b0, b_tr} + {2'b00, carry_q};
      t_carry = (t >= 3'd3);
      t_sum   = t_carry ? 2'(t - 3'd3) : t[1:0];
      work_d  = work_q;
      work_d[{idx_q, 1'b0} +: 2] = t_sum;
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && !bad_in) state_d = RUN;
         RUN:     if (last)             state_d = IDLE;
         default:                       state_d = IDLE;
      endcase
   end

   // Output logic.
   always_comb begin
      busy = (state_q == RUN);
   end

   // Datapath: outputs only move on a completion edge, never with partial results.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the working registers are reset too; they are few flops and a reset-abort must leave no stale state.
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         op_q    <= 1'b0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 2'b00;
         err_q   <= 1'b0;
         acc_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (state_q == IDLE) begin
            if (clr) acc_q <= '0;
            if (start) begin
               a_q     <= a;
               b_q     <= b_sel;
               op_q    <= op;
               carry_q <= cin[0];
               idx_q   <= '0;
               work_q  <= '0;
               if (bad_in) begin
                  sum_q  <= '0;
                  cout_q <= 2'b00;
                  err_q  <= 1'b1;
                  done_q <= 1'b1;
               end
            end
         end else begin
            work_q  <= work_d;
            carry_q <= t_carry;
            idx_q   <= idx_q + IW'(1);
            if (last) begin
               sum_q  <= work_d;
               cout_q <= {1'b0, t_carry};
               err_q  <= 1'b0;
               done_q <= 1'b1;
               if (op_q) acc_q <= work_d;
            end
         end
      end
   end

   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign err  = err_q;
   assign acc  = acc_q;

endmodule
